mem_port_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between the CPU's instruction-fetch requester and its load/store requester.
- Sits between the CPU core and the memory/bus model. It sequences each access as request, wait-for-ack and completion, and reports a timeout error if memory never responds.
- Used by the multi-cycle/stalling CPU variant that replaces separate instruction and data memories.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/arb_pick.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified memory-port arbiter:
//   - FSM state encodings (IDLE / REQ / DONE)
//   - requester id constants (GNT_IF, GNT_D)
//   - helper that sizes the timeout counter from TO_CYCLES
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Requester ids
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // The counter only has to reach TO_CYCLES-1, so clog2(TO_CYCLES) bits
    // suffice; never go below one bit.
    function automatic int cnt_width(input int to_cycles);
        if (to_cycles <= 2) begin
            return 1;
        end
        return $clog2(to_cycles);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational winner select between the fetch and data requesters.
//
// Configuration macro: ARB_RR_EN
//   undefined : fixed priority, data beats fetch
//   defined   : on a tie, grant the requester that was not served last
//
// Ports:
//   if_req   in   fetch request
//   d_req    in   data request
//   last_id  in   requester served last (only with ARB_RR_EN)
//   any_req  out  at least one request pending
//   gnt_id   out  winning requester id (meaningful when any_req=1)
// ---------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef ARB_RR_EN
    input  logic last_id,
`endif
    output logic any_req,
    output logic gnt_id
);

    always_comb begin
        any_req = if_req | d_req;
        gnt_id  = GNT_IF;
`ifdef ARB_RR_EN
        if (if_req && d_req) begin
            // Tie: hand the port to whoever did not get it last time.
            gnt_id = (last_id == GNT_D) ? GNT_IF : GNT_D;
        end else if (d_req) begin
            gnt_id = GNT_D;
        end
`else
        if (d_req) begin
            gnt_id = GNT_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one variable-latency memory port between the instruction-fetch
// requester and the load/store requester. Each access runs
// IDLE (arbitrate + latch) -> REQ (wait for ack or timeout) -> DONE (pulse).
//
// Configuration macro: ARB_RR_EN (round-robin on ties; default is fixed
// priority data > fetch).
//
// Parameters: AW address width, DW data width, TO_CYCLES max REQ cycles
// without mem_ack before the access is aborted with err=1 (>= 2).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request (held until if_done)
//   if_done/if_rdata              fetch completion pulse / fetched word
//   d_req/d_we/d_addr/d_wdata     data request (held until d_done)
//   d_done/d_rdata                data completion pulse / load data
//   err                           valid with a done pulse, 1 = timed out
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     memory request side (stable during REQ)
//   mem_rdata/mem_ack             memory response (ack is single-cycle)
//   busy                          FSM not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy
);

    localparam int            CW      = cnt_width(TO_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TO_CYCLES - 1);

    logic [1:0]    state_reg;
    logic          id_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [CW-1:0] cnt_reg;
    logic          err_reg;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] d_rdata_reg;

    logic          any_req;
    logic          gnt_id;

`ifdef ARB_RR_EN
    logic          last_reg;
`endif

    arb_pick u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
`ifdef ARB_RR_EN
        .last_id (last_reg),
`endif
        .any_req (any_req),
        .gnt_id  (gnt_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            id_reg       <= GNT_IF;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
`ifdef ARB_RR_EN
            // "fetch served last" so the first tie after reset goes to data
            last_reg     <= GNT_IF;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        // Latch everything now; requester changes during the
                        // access are deliberately ignored.
                        id_reg  <= gnt_id;
                        cnt_reg <= '0;
                        if (gnt_id == GNT_D) begin
                            we_reg    <= d_we;
                            addr_reg  <= d_addr;
                            wdata_reg <= d_wdata;
                        end else begin
                            we_reg    <= 1'b0;
                            addr_reg  <= if_addr;
                            wdata_reg <= '0;
                        end
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // Ack is checked before the timeout, so an ack arriving
                    // on the expiry cycle still completes cleanly.
                    if (mem_ack) begin
                        err_reg <= 1'b0;
                        if (id_reg == GNT_IF) begin
                            if_rdata_reg <= mem_rdata;
                        end else if (!we_reg) begin
                            d_rdata_reg <= mem_rdata;
                        end
                        state_reg <= DONE;
                    end else if (cnt_reg == CNT_MAX) begin
                        err_reg <= 1'b1;
                        if (id_reg == GNT_IF) begin
                            if_rdata_reg <= '0;
                        end else begin
                            d_rdata_reg <= '0;
                        end
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
`ifdef ARB_RR_EN
                    last_reg  <= id_reg;
`endif
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset removes them immediately.
    assign mem_req   = (state_reg == REQ);
    assign busy      = (state_reg != IDLE);
    assign if_done   = (state_reg == DONE) && (id_reg == GNT_IF);
    assign d_done    = (state_reg == DONE) && (id_reg == GNT_D);
    assign err       = (state_reg == DONE) && err_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    mem_port_arbiter #(.AW(32), .DW(32), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;        // REQ cycle carrying mem_ack, 0 = never
        logic [31:0] rsp;
        bit          drop_early;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          lat;        // cycles from drive to done
        int          reqs;       // cycles mem_req stays high
    } vec_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          req_cnt = 0;
    int          ack_dly = 0;
    logic [31:0] rsp_data = '0;
    bit          late_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Memory model: acks on the ack_dly-th consecutive REQ cycle.
    initial begin
        int mcnt;
        mcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mcnt++;
                mem_ack = (ack_dly != 0) && (mcnt == ack_dly);
                mem_rdata = mem_ack ? rsp_data : 32'hDEAD_BEEF;
            end else begin
                mcnt = 0;
                mem_ack = late_ack;
                mem_rdata = late_ack ? 32'hFFFF_0000 : 32'h0;
            end
        end
    end

    // Scoreboard monitor: compares in-flight request fields and each done.
    initial begin
        exp_t        e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_cnt = 0;
            end else begin
                if (if_done && d_done) chk("done_excl", 32'd1, 32'd0);
                if (mem_req) begin
                    req_cnt++;
                    if (sb.size() > 0) begin
                        chk("mem_we", {31'b0, mem_we}, {31'b0, sb[0].we});
                        chk("mem_addr", mem_addr, sb[0].addr);
                        chk("mem_wdata", mem_wdata, sb[0].wdata);
                    end
                end
                if (if_done || d_done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done if_done=%0b d_done=%0b required=none (t=%0t)",
                                 if_done, d_done, $time);
                    end else begin
                        e = sb.pop_front();
                        r = e.is_d ? d_rdata : if_rdata;
                        $display("txn %s addr=%h rdata=%h err=%0b cyc=%0d",
                                 e.is_d ? "D " : "IF", e.addr, r, err, cyc);
                        chk("done_id", {31'b0, d_done}, {31'b0, e.is_d});
                        chk("rdata", r, e.rdata);
                        chk("err", {31'b0, err}, {31'b0, e.err});
                        chk("latency", 32'(cyc), 32'(e.cyc));
                        chk("req_cycles", 32'(req_cnt), 32'(e.reqs));
                    end
                    req_cnt = 0;
                    n_done++;
                end
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_done < target) begin
            checks++;
            errors++;
            $display("FAIL wait_done done_count=%0d required=%0d", n_done, target);
        end
    endtask

    task automatic push(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input bit e_err, input int e_cyc, input int reqs);
        exp_t e;
        e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.err = e_err; e.cyc = e_cyc; e.reqs = reqs;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        int base;
        ack_dly = v.dly;
        rsp_data = v.rsp;
        push(v.is_d, v.is_d ? v.we : 1'b0, v.addr, v.is_d ? v.wdata : 32'h0,
             v.exp_rdata, v.exp_err, cyc + v.lat, v.reqs);
        base = n_done;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        if (v.drop_early) begin
            @(negedge clk);
            #1;
            if_req = 1'b0; d_req = 1'b0;
            if_addr = 32'hFFFF_FFFC; d_addr = 32'hFFFF_FFFC;
        end
        wait_done(base + 1, 40);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        int base;
        vecs[0] = '{0, 0, 32'h10,  32'h0,         3, 32'h0050_0093, 0, 32'h0050_0093, 0, 4, 3};
        vecs[1] = '{1, 1, 32'h100, 32'h1234_5678, 1, 32'hAAAA_5555, 0, 32'h0,         0, 2, 1};
        vecs[2] = '{1, 0, 32'h104, 32'h0,         2, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 3, 2};
        vecs[3] = '{1, 1, 32'h108, 32'h0BAD_0BAD, 1, 32'h1111_1111, 0, 32'hCAFE_F00D, 0, 2, 1};
        vecs[4] = '{1, 0, 32'h200, 32'h0,         0, 32'h0,         0, 32'h0,         1, TO + 1, TO};
        vecs[5] = '{0, 0, 32'h14,  32'h0,        TO, 32'h7777_0001, 0, 32'h7777_0001, 0, TO + 1, TO};
        vecs[6] = '{0, 0, 32'h18,  32'h0,         2, 32'h1357_9BDF, 1, 32'h1357_9BDF, 0, 3, 2};
        vecs[7] = '{0, 0, 32'h1C,  32'h0,         0, 32'h0,         0, 32'h0,         1, TO + 1, TO};
        vecs[8] = '{1, 1, 32'h300, 32'h55AA_55AA, 0, 32'h0,         0, 32'h0,         1, TO + 1, TO};
        vecs[9] = '{1, 0, 32'h304, 32'h0,         1, 32'h2468_ACE0, 0, 32'h2468_ACE0, 0, 2, 1};

        #1 rst = 1'b1;
        #2;
        chk("rst_if_done", {31'b0, if_done}, 32'h0);
        chk("rst_d_done", {31'b0, d_done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
            if (i == 4) begin
                // A stray ack while idle must not start or finish anything.
                late_ack = 1'b1;
                @(negedge clk);
                #1 late_ack = 1'b0;
                @(negedge clk);
                #1;
                chk("late_ack_busy", {31'b0, busy}, 32'h0);
                chk("late_ack_mem_req", {31'b0, mem_req}, 32'h0);
            end
        end

        // Reset during the third REQ cycle of a never-acked fetch.
        ack_dly = 0;
        if_req = 1'b1;
        if_addr = 32'h40;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_if_done", {31'b0, if_done}, 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        begin
            vec_t v;
            v = '{0, 0, 32'h44, 32'h0, 1, 32'h0BEE_F00D, 0, 32'h0BEE_F00D, 0, 2, 1};
            run_vec(v);
        end

        // Tie: both rise together, each held until its own done.
        ack_dly = 1;
        rsp_data = 32'h5A5A_0001;
        push(1, 0, 32'h500, 32'h0, 32'h5A5A_0001, 0, cyc + 2, 1);
        push(0, 0, 32'h50,  32'h0, 32'h5A5A_0001, 0, cyc + 5, 1);
        base = n_done;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_wdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h50;
        wait_done(base + 1, 20);
        d_req = 1'b0;
        wait_done(base + 2, 20);
        if_req = 1'b0;
        @(negedge clk);
        #1;

        // Both held continuously.
        rsp_data = 32'h5A5A_0002;
        base = n_done;
`ifdef ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(1, 0, 32'h600, 32'h0, 32'h5A5A_0002, 0, cyc + 2 + 3 * i, 1);
            else            push(0, 0, 32'h60,  32'h0, 32'h5A5A_0002, 0, cyc + 2 + 3 * i, 1);
        end
`else
        for (int i = 0; i < 4; i++) begin
            push(1, 0, 32'h600, 32'h0, 32'h5A5A_0002, 0, cyc + 2 + 3 * i, 1);
        end
        push(0, 0, 32'h60, 32'h0, 32'h5A5A_0002, 0, cyc + 14, 1);
`endif
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_wdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h60;
        wait_done(base + 4, 40);
`ifdef ARB_RR_EN
        d_req = 1'b0;
        if_req = 1'b0;
`else
        d_req = 1'b0;
        wait_done(base + 5, 20);
        if_req = 1'b0;
`endif
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("final_busy", {31'b0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
